// File: rtl/dlx_pkg.sv
// Shared DLX front-end types: address/instruction widths and the fetch FIFO entry.
package dlx_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] word;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc, word} FIFO between instruction memory and the decoder.
module fetch_fifo
    import dlx_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_push,
    input  fetch_entry_t i_data,
    input  logic         i_pop,
    input  logic         i_flush,
    output fetch_entry_t o_head,
    output logic [1:0]   o_count
);

    fetch_entry_t r_mem [2];
    logic         r_rd_ptr;
    logic         r_wr_ptr;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    assign w_pop  = i_pop && (r_count != 2'd0);
    // A full FIFO can still take a push when the head leaves in the same cycle
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// DLX instruction fetch: one outstanding imem request, 2-entry FIFO, redirect/drain handling.
// Define FETCH_UNIT_BYPASS_EN to forward a response straight to the decoder when the FIFO is empty.
module fetch_unit
    import dlx_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned       IMEM_LAT_MIN = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [ADDR_W-1:0]  instr_pc_plus4
);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] w_fetch_pc_nxt;
    logic [ADDR_W-1:0] r_req_addr;
    logic              r_outstanding;
    logic              w_outstanding_nxt;
    logic              w_req;
    logic              w_resp_acc;
    logic [ADDR_W-1:0] w_redirect_pc;
    logic [1:0]        w_count;
    logic              w_fifo_valid;
    logic              w_bypass;
    logic              w_out_valid;
    logic              w_push;
    logic              w_pop;
    fetch_entry_t      w_head;
    fetch_entry_t      w_resp_entry;
    fetch_entry_t      w_out_entry;
    logic [7:0]        r_lat;

    assign w_redirect_pc = redirect_pc & ~ADDR_W'(3);
    assign w_resp_entry  = '{pc: r_req_addr, word: imem_rdata};
    assign w_fifo_valid  = (w_count != 2'd0);

    // Next-state, request and response-acceptance decisions
    always_comb begin
        w_state_nxt       = r_state;
        w_fetch_pc_nxt    = r_fetch_pc;
        w_outstanding_nxt = r_outstanding;
        w_req             = 1'b0;
        w_resp_acc        = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_req      = reset_n && !r_outstanding && (w_count < 2'd2) && !redirect_valid;
                w_resp_acc = imem_rvalid && r_outstanding && !redirect_valid;
                if (redirect_valid) begin
                    w_fetch_pc_nxt = w_redirect_pc;
                    if (r_outstanding && !imem_rvalid) w_state_nxt = ST_DRAIN;
                    else                               w_outstanding_nxt = 1'b0;
                end else if (w_req && imem_gnt) begin
                    w_fetch_pc_nxt    = r_fetch_pc + ADDR_W'(4);
                    w_outstanding_nxt = 1'b1;
                end else if (w_resp_acc) begin
                    w_outstanding_nxt = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (redirect_valid) w_fetch_pc_nxt = w_redirect_pc;
                if (imem_rvalid) begin
                    w_state_nxt       = ST_RUN;
                    w_outstanding_nxt = 1'b0;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_RUN;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= 1'b0;
            r_req_addr    <= '0;
        end else begin
            r_fetch_pc    <= w_fetch_pc_nxt;
            r_outstanding <= w_outstanding_nxt;
            if (w_req && imem_gnt) r_req_addr <= r_fetch_pc;
        end
    end

`ifdef FETCH_UNIT_BYPASS_EN
    assign w_bypass = w_resp_acc && !w_fifo_valid;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_out_valid = w_fifo_valid || w_bypass;
    assign w_out_entry = w_fifo_valid ? w_head : w_resp_entry;
    assign w_pop       = w_fifo_valid && instr_ready;
    assign w_push      = w_resp_acc && !(w_bypass && instr_ready);

    fetch_fifo u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_data  (w_resp_entry),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign imem_req       = w_req;
    assign imem_addr      = r_fetch_pc;
    assign instr_valid    = w_out_valid;
    assign instr          = w_out_valid ? w_out_entry.word : NOP_INSTR;
    assign instr_pc       = w_out_valid ? w_out_entry.pc : '0;
    assign instr_pc_plus4 = w_out_valid ? (w_out_entry.pc + ADDR_W'(4)) : '0;

    // Cycles since the last grant, to catch memories answering faster than IMEM_LAT_MIN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                r_lat <= '0;
        else if (w_req && imem_gnt)  r_lat <= '0;
        else if (r_lat != 8'hFF)     r_lat <= r_lat + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset_n && imem_rvalid && r_outstanding)
            assert (32'(r_lat) + 32'd1 >= IMEM_LAT_MIN)
                else $error("imem response earlier than IMEM_LAT_MIN");
    end

endmodule
